// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared constants and types for the UART boot loader.
//   SYNC_BYTE / CMD_*  : packet framing and command codes
//   CSUM_EN            : 1 when UART_LOADER_CHECKSUM_EN is defined (a trailing
//                        CSUM byte is expected and checked), 0 otherwise
//   state_e            : one-hot packet parser state
//   done_state()       : state entered once a packet's payload is complete
package uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_HALT  = 8'h03;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef enum logic [6:0] {
        ST_SYNC  = 7'b000_0001,
        ST_CMD   = 7'b000_0010,
        ST_ADDR  = 7'b000_0100,
        ST_LEN   = 7'b000_1000,
        ST_DATA  = 7'b001_0000,
        ST_WRITE = 7'b010_0000,
        ST_CSUM  = 7'b100_0000
    } state_e;

    // Without a checksum byte the packet ends as soon as its payload does.
    function automatic state_e done_state();
        if (CSUM_EN) begin
            return ST_CSUM;
        end else begin
            return ST_SYNC;
        end
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: byte stream in, memory write port and status out.
//   S_axis_tdata/tvalid/tready : byte stream from uart_rx
//   Mem_we/Mem_addr/Mem_wdata  : single-cycle word write port
//   Cpu_rst/Busy/Err           : CPU hold, packet-in-progress, sticky error
// Modports: slave = the loader, master = the environment driving it.
interface uart_loader_if #(
    parameter int MEM_ADDR_W = 10
);
    logic [7:0]            S_axis_tdata;
    logic                  S_axis_tvalid;
    logic                  S_axis_tready;
    logic                  Mem_we;
    logic [MEM_ADDR_W-1:0] Mem_addr;
    logic [31:0]           Mem_wdata;
    logic                  Cpu_rst;
    logic                  Busy;
    logic                  Err;

    modport slave (
        input  S_axis_tdata, S_axis_tvalid,
        output S_axis_tready, Mem_we, Mem_addr, Mem_wdata, Cpu_rst, Busy, Err
    );

    modport master (
        output S_axis_tdata, S_axis_tvalid,
        input  S_axis_tready, Mem_we, Mem_addr, Mem_wdata, Cpu_rst, Busy, Err
    );
endinterface

// File: rtl/uart_loader_byte_timeout.sv
// byte_timeout: loadable down-counter measuring idle cycles between bytes.
//   Clk, Rst : clock, synchronous active-high reset
//   clr      : reload the counter (a byte was accepted, or parser is idle)
//   expired  : high once TIMEOUT_CYCLES-1 cycles have passed since the last clr
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    output logic expired
);
    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on clear, otherwise count down and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses SYNC/CMD/payload[/CSUM] packets from uart_rx, writes
// little-endian 32-bit words to memory and holds the CPU in reset until RUN.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : uart_loader_if.slave (byte stream in, memory port and status out)
// Build option: define UART_LOADER_CHECKSUM_EN to expect and check a trailing
// CSUM byte; without it the command acts as soon as its payload is complete.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int MEM_ADDR_W     = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic          Clk,
    input logic          Rst,
    uart_loader_if.slave bus
);
    state_e                state_q, state_d;
    logic [31:0]           word_q, word_d;        // bytes shift in from the top
    logic [1:0]            bidx_q, bidx_d;        // byte index within a field/word
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]           cnt_q, cnt_d;          // words still to write
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            cmd_q, cmd_d;
    logic                  mem_we_q, mem_we_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  err_q, err_d;

    logic        tready_s, hs_s, tmo_clr_s, tmo_exp_s, timeout_s;
    logic        err_set_s, err_clr_s;
    logic [31:0] word_shift_s;
    logic [15:0] field_s;
    logic [7:0]  sum_next_s;

    assign tready_s     = (state_q != ST_WRITE);
    assign hs_s         = bus.S_axis_tvalid & tready_s;
    assign word_shift_s = {bus.S_axis_tdata, word_q[31:8]};
    // Second byte of a 16-bit LE field; the first byte sits in word_q[31:24].
    assign field_s      = {bus.S_axis_tdata, word_q[31:24]};
    assign sum_next_s   = sum_q + bus.S_axis_tdata;
    assign tmo_clr_s    = hs_s | (state_q == ST_SYNC);
    assign timeout_s    = tmo_exp_s & (state_q != ST_SYNC) & (state_q != ST_WRITE);

    byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .Clk     (Clk),
        .Rst     (Rst),
        .clr     (tmo_clr_s),
        .expired (tmo_exp_s)
    );

    // Packet parser: next state, field assembly and output updates.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bidx_d      = bidx_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cmd_d       = cmd_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        err_set_s   = 1'b0;
        err_clr_s   = 1'b0;

        if (timeout_s) begin
            // Abort: any partially assembled word is simply dropped.
            state_d   = ST_SYNC;
            bidx_d    = 2'd0;
            err_set_s = 1'b1;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (hs_s && (bus.S_axis_tdata == SYNC_BYTE)) begin
                        state_d   = ST_CMD;
                        err_clr_s = 1'b1;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_CMD: begin
                    if (hs_s) begin
                        sum_d  = bus.S_axis_tdata;
                        cmd_d  = bus.S_axis_tdata;
                        bidx_d = 2'd0;
                        case (bus.S_axis_tdata)
                            CMD_WRITE: begin
                                cpu_rst_d = 1'b1;
                                state_d   = ST_ADDR;
                            end
                            CMD_RUN, CMD_HALT: begin
                                if (CSUM_EN) begin
                                    state_d = ST_CSUM;
                                end else begin
                                    cpu_rst_d = (bus.S_axis_tdata == CMD_HALT);
                                    state_d   = ST_SYNC;
                                end
                            end
                            default: begin
                                err_set_s = 1'b1;
                                state_d   = ST_SYNC;
                            end
                        endcase
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (hs_s) begin
                        word_d = word_shift_s;
                        sum_d  = sum_next_s;
                        bidx_d = bidx_q + 2'd1;
                        if (bidx_q == 2'd1) begin
                            addr_d  = MEM_ADDR_W'(field_s);
                            bidx_d  = 2'd0;
                            state_d = ST_LEN;
                        end else begin
                            state_d = ST_ADDR;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_LEN: begin
                    if (hs_s) begin
                        word_d = word_shift_s;
                        sum_d  = sum_next_s;
                        bidx_d = bidx_q + 2'd1;
                        if (bidx_q == 2'd1) begin
                            cnt_d  = field_s;
                            bidx_d = 2'd0;
                            if (field_s == 16'd0) begin
                                state_d = done_state();
                            end else begin
                                state_d = ST_DATA;
                            end
                        end else begin
                            state_d = ST_LEN;
                        end
                    end else begin
                        state_d = ST_LEN;
                    end
                end
                ST_DATA: begin
                    if (hs_s) begin
                        word_d = word_shift_s;
                        sum_d  = sum_next_s;
                        bidx_d = bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            // Write strobe is registered so it coincides with ST_WRITE.
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_q;
                            mem_wdata_d = word_shift_s;
                            state_d     = ST_WRITE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_WRITE: begin
                    addr_d = addr_q + {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = done_state();
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (hs_s) begin
                        state_d = ST_SYNC;
                        if (sum_next_s == 8'h00) begin
                            case (cmd_q)
                                CMD_RUN:  cpu_rst_d = 1'b0;
                                CMD_HALT: cpu_rst_d = 1'b1;
                                default:  cpu_rst_d = cpu_rst_q;
                            endcase
                        end else begin
                            err_set_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_CSUM;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end

        // An error event outranks the clearing sync byte.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_SYNC;
            word_q      <= 32'h0000_0000;
            bidx_q      <= 2'd0;
            addr_q      <= {MEM_ADDR_W{1'b0}};
            cnt_q       <= 16'd0;
            sum_q       <= 8'h00;
            cmd_q       <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {MEM_ADDR_W{1'b0}};
            mem_wdata_q <= 32'h0000_0000;
            cpu_rst_q   <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bidx_q      <= bidx_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cmd_q       <= cmd_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            err_q       <= err_d;
        end
    end

    assign bus.S_axis_tready = tready_s;
    assign bus.Mem_we        = mem_we_q;
    assign bus.Mem_addr      = mem_addr_q;
    assign bus.Mem_wdata     = mem_wdata_q;
    assign bus.Cpu_rst       = cpu_rst_q;
    assign bus.Busy          = (state_q != ST_SYNC);
    assign bus.Err           = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized packet stimulus with a scoreboard of expected
// memory writes and a packet-level model of Cpu_rst / Err.
module tb_uart_loader;
    localparam int AW = 10;
    localparam int TO = 64;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    uart_loader_if #(.MEM_ADDR_W(AW)) bus ();

    uart_loader #(.MEM_ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic exp_cpu_rst = 1'b1;
    logic exp_err     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_tready",  {31'd0, bus.S_axis_tready}, 32'd1);
        chk("rst_mem_we",  {31'd0, bus.Mem_we},        32'd0);
        chk("rst_addr",    32'(bus.Mem_addr),          32'd0);
        chk("rst_wdata",   bus.Mem_wdata,              32'd0);
        chk("rst_cpu_rst", {31'd0, bus.Cpu_rst},       32'd1);
        chk("rst_busy",    {31'd0, bus.Busy},          32'd0);
        chk("rst_err",     {31'd0, bus.Err},           32'd0);
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge Clk) begin
        wr_t e;
        if (Rst == 1'b0) begin
            chk("tready_low_iff_write", {31'd0, bus.S_axis_tready}, {31'd0, ~bus.Mem_we});
            if (bus.Mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                             bus.Mem_addr, bus.Mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(bus.Mem_addr), 32'(e.a));
                    chk("write_data", bus.Mem_wdata, e.d);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k;
        k = 0;
        @(negedge Clk);
        bus.S_axis_tdata  = b;
        bus.S_axis_tvalid = 1'b1;
        while (bus.S_axis_tready !== 1'b1 && k < 50) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 50) chk("tready_wait", 32'd0, 32'd1);
        @(posedge Clk);
        #1;
        bus.S_axis_tvalid = 1'b0;
        if (gap && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
    endtask

    task automatic run_packet(input logic [7:0] cmd, input logic [15:0] addr, input int len,
                              input bit corrupt, input int garbage, input logic [31:0] w0);
        logic [7:0]  pl[$];
        logic [7:0]  sum;
        logic [31:0] w;
        logic        pre_cpu;
        bit          known;
        wr_t         e;
        sum = 8'h00;
        for (int g = 0; g < garbage; g++) begin
            logic [7:0] gb;
            gb = 8'($urandom_range(0, 255));
            if (gb == 8'hA5) gb = 8'h5A;
            send_byte(gb, 1'b1);
        end
        pl.push_back(cmd);
        if (cmd == 8'h01) begin
            pl.push_back(addr[7:0]);
            pl.push_back(addr[15:8]);
            pl.push_back(8'(len));
            pl.push_back(8'(len >> 8));
            for (int i = 0; i < len; i++) begin
                w = (i == 0) ? w0 : $urandom;
                for (int j = 0; j < 4; j++) pl.push_back(8'(w >> (8 * j)));
                e.a = AW'((int'(addr) + i) % (1 << AW));
                e.d = w;
                exp_q.push_back(e);
            end
        end
        foreach (pl[i]) sum = sum + pl[i];
        known = (cmd >= 8'h01 && cmd <= 8'h03);
        if (CS && known) pl.push_back(corrupt ? 8'(8'h01 - sum) : 8'(8'h00 - sum));

        // Packet-level expectations.
        pre_cpu = (cmd == 8'h01) ? 1'b1 : exp_cpu_rst;
        exp_err = 1'b0;
        if (!known) begin
            exp_err = 1'b1;
        end else begin
            if (cmd == 8'h01) exp_cpu_rst = 1'b1;
            if (CS && corrupt) exp_err = 1'b1;
            else if (cmd == 8'h02) exp_cpu_rst = 1'b0;
            else if (cmd == 8'h03) exp_cpu_rst = 1'b1;
        end

        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < pl.size(); i++) begin
            if (i == pl.size() - 1) begin
                chk("cpu_rst_before_last", {31'd0, bus.Cpu_rst}, {31'd0, pre_cpu});
                send_byte(pl[i], 1'b0);
            end else begin
                send_byte(pl[i], 1'b1);
            end
        end
        @(negedge Clk);
        chk("cpu_rst_after", {31'd0, bus.Cpu_rst}, {31'd0, exp_cpu_rst});
        chk("err_after",     {31'd0, bus.Err},     {31'd0, exp_err});
        repeat (4) @(negedge Clk);
        chk("busy_idle",     {31'd0, bus.Busy},    32'd0);
        chk("writes_done",   32'(exp_q.size()),    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int r;
        bus.S_axis_tdata  = 8'h00;
        bus.S_axis_tvalid = 1'b0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk_reset_vals();

        // A5 01 10 00 01 00 78 56 34 12 DA
        run_packet(8'h01, 16'h0010, 1, 1'b0, 0, 32'h1234_5678);
        run_packet(8'h02, 16'h0000, 0, 1'b0, 0, 32'h0);   // RUN
        run_packet(8'h03, 16'h0000, 0, 1'b0, 0, 32'h0);   // HALT
        run_packet(8'h01, 16'h03FF, 2, 1'b0, 2, $urandom); // address wrap
        run_packet(8'h01, 16'h0123, 1, 1'b1, 0, $urandom); // corrupted checksum
        run_packet(8'h02, 16'h0000, 0, 1'b0, 0, 32'h0);   // sync clears Err
        run_packet(8'h01, 16'h0200, 0, 1'b0, 0, 32'h0);   // LEN = 0

        // Stall mid-packet until the byte timeout fires.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h10, 1'b0);
        @(negedge Clk);
        chk("busy_mid_packet", {31'd0, bus.Busy}, 32'd1);
        repeat (TO + 4) @(negedge Clk);
        exp_err     = 1'b1;
        exp_cpu_rst = 1'b1;
        chk("timeout_err",     {31'd0, bus.Err},     32'd1);
        chk("timeout_busy",    {31'd0, bus.Busy},    32'd0);
        chk("timeout_cpu_rst", {31'd0, bus.Cpu_rst}, 32'd1);

        run_packet(8'h07, 16'h0000, 0, 1'b0, 0, 32'h0);   // unknown command

        // Reset in the middle of a data word.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk_reset_vals();
        exp_cpu_rst = 1'b1;
        exp_err     = 1'b0;
        run_packet(8'h01, 16'h0020, 1, 1'b0, 0, 32'hCAFE_F00D);

        // Randomized packets.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      c = 8'h01;
            else if (r == 6) c = 8'h02;
            else if (r == 7) c = 8'h03;
            else             c = 8'($urandom_range(4, 255));
            run_packet(c, 16'($urandom), $urandom_range(0, 3),
                       ($urandom_range(0, 4) == 0), $urandom_range(0, 2), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
